// File: rtl/dummy_mc_model_if.sv
// rtl/dummy_mc_model_if.sv - MC port request/response bundle between phold and the memory model
interface dummy_mc_model_if #(
    parameter int MC_RTNCTL_WIDTH = 32
);
    logic                       mc_rq_vld;
    logic [2:0]                 mc_rq_cmd;
    logic [3:0]                 mc_rq_scmd;
    logic [47:0]                mc_rq_vadr;
    logic [1:0]                 mc_rq_size;
    logic [MC_RTNCTL_WIDTH-1:0] mc_rq_rtnctl;
    logic [63:0]                mc_rq_data;
    logic                       mc_rq_flush;
    logic                       mc_rq_stall;
    logic                       mc_rs_vld;
    logic [2:0]                 mc_rs_cmd;
    logic [3:0]                 mc_rs_scmd;
    logic [MC_RTNCTL_WIDTH-1:0] mc_rs_rtnctl;
    logic [63:0]                mc_rs_data;
    logic                       mc_rs_stall;

    modport master (
        output mc_rq_vld, mc_rq_cmd, mc_rq_scmd, mc_rq_vadr, mc_rq_size,
               mc_rq_rtnctl, mc_rq_data, mc_rq_flush, mc_rs_stall,
        input  mc_rq_stall, mc_rs_vld, mc_rs_cmd, mc_rs_scmd, mc_rs_rtnctl, mc_rs_data
    );

    modport slave (
        input  mc_rq_vld, mc_rq_cmd, mc_rq_scmd, mc_rq_vadr, mc_rq_size,
               mc_rq_rtnctl, mc_rq_data, mc_rq_flush, mc_rs_stall,
        output mc_rq_stall, mc_rs_vld, mc_rs_cmd, mc_rs_scmd, mc_rs_rtnctl, mc_rs_data
    );
endinterface

// File: rtl/dummy_mc_model.sv
// rtl/dummy_mc_model.sv - behavioural MC port model: 64-bit word RAM plus in-order response queue
module dummy_mc_model #(
    parameter int MC_RTNCTL_WIDTH = 32,
    parameter int RAM_DEPTH       = 512,
    parameter int RSP_FIFO_DEPTH  = 16
) (
    input  logic            clk,
    input  logic            reset,
    dummy_mc_model_if.slave bus
);
    localparam int AW = $clog2(RAM_DEPTH);
    localparam int PW = $clog2(RSP_FIFO_DEPTH);

    typedef struct packed {
        logic [2:0]                 cmd;
        logic [MC_RTNCTL_WIDTH-1:0] rtnctl;
        logic [63:0]                data;
    } rsp_t;

    logic [63:0] r_mem [RAM_DEPTH] = '{default: 64'h0};
    rsp_t        r_q   [RSP_FIFO_DEPTH];
    logic [PW-1:0] r_wr, r_rd;
    logic [PW:0]   r_count;
    logic          r_stall;
    logic          r_rs_vld;
    rsp_t          r_head;

    logic [AW-1:0] w_idx;
    logic          w_accept, w_is_rd, w_is_wr, w_push_rq, w_push_fl, w_pop;
    logic [PW-1:0] w_fl_slot, w_rd_nxt;
    logic [PW:0]   w_count_nxt;
    rsp_t          w_rq_ent, w_fl_ent, w_head_nxt;
    logic          w_unused;

    assign w_idx     = bus.mc_rq_vadr[3 +: AW];
    assign w_accept  = bus.mc_rq_vld && !r_stall;
    assign w_is_rd   = bus.mc_rq_cmd == 3'd1;
    assign w_is_wr   = bus.mc_rq_cmd == 3'd2;
    assign w_push_rq = w_accept && (w_is_rd || w_is_wr);
    assign w_push_fl = bus.mc_rq_flush && !r_stall;
    assign w_pop     = r_rs_vld && !bus.mc_rs_stall;

    assign w_rq_ent = '{cmd:    w_is_rd ? 3'd2 : 3'd3,
                        rtnctl: bus.mc_rq_rtnctl,
                        data:   w_is_rd ? r_mem[w_idx] : 64'h0};
    assign w_fl_ent = '{cmd: 3'd7, rtnctl: '0, data: 64'h0};

    // Request entry goes ahead of a same-cycle flush entry.
    assign w_fl_slot   = r_wr + PW'(w_push_rq);
    assign w_rd_nxt    = r_rd + PW'(w_pop);
    assign w_count_nxt = r_count + (PW+1)'(w_push_rq) + (PW+1)'(w_push_fl) - (PW+1)'(w_pop);

    // Head register is loaded with the post-edge head, bypassing storage when that slot is being written.
    always_comb begin
        w_head_nxt = r_q[w_rd_nxt];
        if (w_push_rq && w_rd_nxt == r_wr)
            w_head_nxt = w_rq_ent;
        else if (w_push_fl && w_rd_nxt == w_fl_slot)
            w_head_nxt = w_fl_ent;
    end

    always_ff @(posedge clk) begin
        if (w_accept && w_is_wr)
            r_mem[w_idx] <= bus.mc_rq_data;
        if (w_push_rq)
            r_q[r_wr] <= w_rq_ent;
        if (w_push_fl)
            r_q[w_fl_slot] <= w_fl_ent;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr     <= '0;
            r_rd     <= '0;
            r_count  <= '0;
            r_stall  <= 1'b0;
            r_rs_vld <= 1'b0;
            r_head   <= '0;
        end else begin
            r_wr     <= r_wr + PW'(w_push_rq) + PW'(w_push_fl);
            r_rd     <= w_rd_nxt;
            r_count  <= w_count_nxt;
            // Threshold leaves room for a request plus a flush landing in the cycle stall appears.
            r_stall  <= w_count_nxt >= (PW+1)'(RSP_FIFO_DEPTH - 2);
            r_rs_vld <= w_count_nxt != '0;
            if (w_count_nxt != '0)
                r_head <= w_head_nxt;
        end
    end

    assign bus.mc_rq_stall  = r_stall;
    assign bus.mc_rs_vld    = r_rs_vld;
    assign bus.mc_rs_cmd    = r_head.cmd;
    assign bus.mc_rs_scmd   = 4'h0;
    assign bus.mc_rs_rtnctl = r_head.rtnctl;
    assign bus.mc_rs_data   = r_head.data;

    assign w_unused = ^{bus.mc_rq_scmd, bus.mc_rq_size, bus.mc_rq_vadr[47:3+AW], bus.mc_rq_vadr[2:0]};
endmodule

// File: tb/tb_dummy_mc_model.sv
// tb/tb_dummy_mc_model.sv - directed bench for dummy_mc_model
module tb_dummy_mc_model;
    localparam logic [63:0] DB = 64'hDEADBEEF_01234567;

    logic clk = 1'b0;
    logic reset;
    int   n_total = 0;
    int   n_pass  = 0;
    int   sent;
    logic acc;

    dummy_mc_model_if #(.MC_RTNCTL_WIDTH(32)) bus ();

    dummy_mc_model #(.MC_RTNCTL_WIDTH(32), .RAM_DEPTH(512), .RSP_FIFO_DEPTH(16)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    task automatic step;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drive_rq(input logic [2:0] cmd, input logic [47:0] adr,
                            input logic [31:0] tag, input logic [63:0] d);
        bus.mc_rq_vld    = 1'b1;
        bus.mc_rq_cmd    = cmd;
        bus.mc_rq_vadr   = adr;
        bus.mc_rq_rtnctl = tag;
        bus.mc_rq_data   = d;
    endtask

    task automatic idle_rq;
        bus.mc_rq_vld   = 1'b0;
        bus.mc_rq_flush = 1'b0;
        bus.mc_rq_cmd   = 3'd0;
    endtask

    task automatic chk_rsp(input string tag, input logic [2:0] cmd,
                           input logic [31:0] rt, input logic [63:0] d);
        chk({tag, ".vld"},    128'(bus.mc_rs_vld),    128'(1'b1));
        chk({tag, ".cmd"},    128'(bus.mc_rs_cmd),    128'(cmd));
        chk({tag, ".rtnctl"}, 128'(bus.mc_rs_rtnctl), 128'(rt));
        chk({tag, ".data"},   128'(bus.mc_rs_data),   128'(d));
        chk({tag, ".scmd"},   128'(bus.mc_rs_scmd),   128'(4'h0));
    endtask

    initial begin
        reset = 1'b1;
        bus.mc_rq_scmd  = 4'h0;
        bus.mc_rq_size  = 2'd3;
        bus.mc_rq_vadr  = '0;
        bus.mc_rq_rtnctl = '0;
        bus.mc_rq_data  = '0;
        bus.mc_rs_stall = 1'b0;
        idle_rq();
        repeat (2) @(negedge clk);
        reset = 1'b0;

        chk("rst.rs_vld",   128'(bus.mc_rs_vld),    128'(1'b0));
        chk("rst.rq_stall", 128'(bus.mc_rq_stall),  128'(1'b0));
        chk("rst.rs_cmd",   128'(bus.mc_rs_cmd),    128'(3'd0));
        chk("rst.rs_rtn",   128'(bus.mc_rs_rtnctl), 128'(32'd0));
        chk("rst.rs_data",  128'(bus.mc_rs_data),   128'(64'd0));

        drive_rq(3'd1, 48'h100, 32'd1, 64'h0);
        step();
        idle_rq();
        chk_rsp("rd_zero", 3'd2, 32'd1, 64'h0);
        step();
        chk("pop_empty.vld", 128'(bus.mc_rs_vld), 128'(1'b0));

        drive_rq(3'd2, 48'h40, 32'd5, DB);
        step();
        chk_rsp("wr40", 3'd3, 32'd5, 64'h0);
        drive_rq(3'd1, 48'h40, 32'd6, 64'h0);
        step();
        chk_rsp("rd40", 3'd2, 32'd6, DB);
        drive_rq(3'd2, 48'h8, 32'd7, 64'hA5);
        step();
        chk_rsp("wr8", 3'd3, 32'd7, 64'h0);
        drive_rq(3'd1, 48'h1008, 32'd8, 64'h0);
        step();
        chk_rsp("rd_wrap", 3'd2, 32'd8, 64'hA5);
        drive_rq(3'd1, 48'h45, 32'd10, 64'h0);
        step();
        chk_rsp("rd_lowbits", 3'd2, 32'd10, DB);
        drive_rq(3'd3, 48'h40, 32'd11, 64'h1);
        step();
        idle_rq();
        chk("badcmd.vld",  128'(bus.mc_rs_vld),    128'(1'b0));
        chk("empty.hold",  128'(bus.mc_rs_rtnctl), 128'(32'd10));
        drive_rq(3'd1, 48'h40, 32'd12, 64'h0);
        step();
        idle_rq();
        chk_rsp("badcmd_nowrite", 3'd2, 32'd12, DB);
        step();

        bus.mc_rs_stall = 1'b1;
        sent = 0;
        for (int c = 0; c < 18; c++) begin
            drive_rq(3'd1, 48'h40, 32'(100 + sent), 64'h0);
            acc = !bus.mc_rq_stall;
            step();
            if (acc) sent++;
        end
        idle_rq();
        chk("bp.accepted", 128'(sent),              128'(14));
        chk("bp.rq_stall", 128'(bus.mc_rq_stall),   128'(1'b1));
        chk("bp.head",     128'(bus.mc_rs_rtnctl),  128'(32'd100));
        bus.mc_rs_stall = 1'b0;
        for (int i = 0; i < 14; i++) begin
            chk_rsp($sformatf("bp.rsp%0d", i), 3'd2, 32'(100 + i), DB);
            step();
        end
        chk("bp.drained", 128'(bus.mc_rs_vld),    128'(1'b0));
        chk("bp.unstall", 128'(bus.mc_rq_stall),  128'(1'b0));

        drive_rq(3'd1, 48'h8, 32'd9, 64'h0);
        bus.mc_rq_flush = 1'b1;
        step();
        idle_rq();
        chk_rsp("fl.rd", 3'd2, 32'd9, 64'hA5);
        step();
        chk_rsp("fl.cmp", 3'd7, 32'd0, 64'h0);
        step();
        chk("fl.empty", 128'(bus.mc_rs_vld), 128'(1'b0));

        bus.mc_rs_stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive_rq(3'd1, 48'h40, 32'(20 + i), 64'h0);
            step();
        end
        idle_rq();
        chk_rsp("ar.queued", 3'd2, 32'd20, DB);
        #2 reset = 1'b1;
        #1;
        chk("ar.vld",   128'(bus.mc_rs_vld),   128'(1'b0));
        chk("ar.stall", 128'(bus.mc_rq_stall), 128'(1'b0));
        chk("ar.cmd",   128'(bus.mc_rs_cmd),   128'(3'd0));
        chk("ar.data",  128'(bus.mc_rs_data),  128'(64'd0));
        @(negedge clk);
        reset = 1'b0;
        bus.mc_rs_stall = 1'b0;
        step();
        chk("ar.dropped", 128'(bus.mc_rs_vld), 128'(1'b0));
        drive_rq(3'd1, 48'h40, 32'd30, 64'h0);
        step();
        chk_rsp("ar.mem40", 3'd2, 32'd30, DB);
        drive_rq(3'd1, 48'h1008, 32'd31, 64'h0);
        step();
        idle_rq();
        chk_rsp("ar.mem8", 3'd2, 32'd31, 64'hA5);
        step();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/dummy_mc_model.md
# dummy_mc_model

Behavioural memory-controller model serving one Convey-style MC port for the phold PDES engine in simulation. It accepts 64-bit read/write requests into a RAM_DEPTH-word internal memory. It returns read data or write completions in request order through a response queue, with backpressure in both directions. It stands in for the real coprocessor memory controller so phold can run standalone against a testbench.

## Interface
Parameters:
- MC_RTNCTL_WIDTH, 32, width of the return-control tag echoed from request to response
- RAM_DEPTH, 512, number of 64-bit words; power of two, at least 2
- RSP_FIFO_DEPTH, 16, response queue entries; power of two, at least 4

Ports:
- clk  in  1  single clock, all logic on rising edge
- reset  in  1  asynchronous, active-high reset
- mc_rq_vld  in  1  request valid
- mc_rq_cmd  in  3  1 = RD, 2 = WR; any other value is ignored
- mc_rq_scmd  in  4  sub-command, ignored
- mc_rq_vadr  in  48  byte address
- mc_rq_size  in  2  access size, ignored; all accesses are 8 bytes
- mc_rq_rtnctl  in  MC_RTNCTL_WIDTH  tag, echoed on the response
- mc_rq_data  in  64  write data
- mc_rq_flush  in  1  flush request
- mc_rq_stall  out  1  model cannot accept requests
- mc_rs_vld  out  1  response valid
- mc_rs_cmd  out  3  2 = RD_DATA, 3 = WR_CMP, 7 = FLUSH_CMP
- mc_rs_scmd  out  4  always 0
- mc_rs_rtnctl  out  MC_RTNCTL_WIDTH  echoed tag
- mc_rs_data  out  64  read data; 0 for WR_CMP and FLUSH_CMP
- mc_rs_stall  in  1  consumer not ready

## Operation
- Word index = mc_rq_vadr[3 +: log2(RAM_DEPTH)]. Upper address bits are discarded, so addresses wrap modulo RAM_DEPTH words. vadr[2:0] is ignored.
- Memory contents are initialised to all-zero at time 0. Reset does not clear memory.
- A request is accepted on a rising edge when mc_rq_vld=1 and mc_rq_stall=0.
- Accepted WR:
  - mem[idx] <= mc_rq_data on that edge.
  - Push {WR_CMP, rtnctl, 64'h0}.
- Accepted RD: push {RD_DATA, rtnctl, mem[idx]}, where mem[idx] is the value before any write on the same edge. Only one request can arrive per cycle, so this only matters for back-to-back RD after WR: a read in the cycle after a write returns the new data.
- Flush accept:
  - Condition: mc_rq_flush=1 and mc_rq_stall=0.
  - Push {FLUSH_CMP, rtnctl=0, data=0}.
  - If mc_rq_vld is also asserted in that cycle, the request entry is pushed first and the flush entry second.
  - Flush has no memory effect.
- An accepted request with an unsupported cmd updates nothing and pushes nothing.
- The response queue is FIFO; responses leave in acceptance order.
- Head of queue drives mc_rs_*.
  - mc_rs_vld=1 whenever the queue is non-empty.
  - The entry pops on an edge where mc_rs_vld=1 and mc_rs_stall=0.

## Timing
- Reset (asynchronous assert, synchronous release by next edge):
  - Queue empties.
  - mc_rs_vld=0, mc_rs_cmd=0, mc_rs_rtnctl=0, mc_rs_data=0, mc_rs_scmd=0, mc_rq_stall=0.
- Reset mid-operation drops all queued responses. Writes already performed remain in memory.
- Latency: a request accepted at edge N appears on mc_rs_* (registered) after edge N, if the queue was empty and not stalled. That is one cycle of latency.
- Throughput: one request and one response per cycle. A push and a pop on the same edge leave the count unchanged.
- mc_rq_stall is registered. It is asserted when count after this edge >= RSP_FIFO_DEPTH-2. This leaves room for a request plus a flush arriving in the cycle the stall appears, so no overflow is possible.
- Requests presented while mc_rq_stall=1 are not accepted. The requester must hold them.
- Empty: mc_rs_vld=0 and response outputs hold their last values.
- While mc_rs_stall=1, the head entry is held stable.

## Test plan
- Reset then idle:
  - reset high 20 ns -> mc_rs_vld=0 and mc_rq_stall=0.
  - Memory read at any address returns 0.
- WR then RD:
  - WR vadr=0x40 data=0xDEADBEEF_01234567 rtnctl=5 -> WR_CMP rtnctl=5 data=0, one cycle later.
  - RD vadr=0x40 rtnctl=6 -> RD_DATA rtnctl=6 data=0xDEADBEEF_01234567.
- Address wrap:
  - WR vadr=0x8 data=0xA5.
  - RD vadr=0x8+8*512=0x1008 -> data=0xA5.
- Backpressure:
  - Hold mc_rs_stall=1 and issue back-to-back RDs -> mc_rq_stall rises once 14 entries are queued, and no request is lost.
  - Release mc_rs_stall -> all 14 responses return in order with correct tags.
- Flush plus request in one cycle: RD rtnctl=9 with mc_rq_flush=1 -> RD_DATA rtnctl=9, then FLUSH_CMP rtnctl=0.
- Async reset mid-stream: assert reset while 3 responses are queued -> mc_rs_vld drops immediately. Earlier writes are still readable after release.
